rr_decoder_arbiter: RTL and testbench
=====================================

// Module: rr_decoder_arbiter
// PURPOSE
//  Round-robin arbiter sharing one downstream resource among 4 requesters.
//  Latches a 2-bit winner index and expands it to a one-hot grant through a
//  2-to-4 decoder with enable. Grant is held until release, then a one-cycle
//  gap follows. Sits between requesting datapath blocks and the shared
//  resource whose select lines the one-hot grant drives.
// PARAMETERS
//  HOLD_MAX  8  max cycles a grant may be held; 0 = no timeout
//  CNT_W     8  width of hold counter; HOLD_MAX <= 2**CNT_W - 1
// PORTS
//  clk      in   1      single clock, rising edge
//  rst_n    in   1      asynchronous, active-low reset
//  req      in   4      request per channel, level; req[i] = channel i
//  done     in   1      holder releases grant (sampled only in GRANT)
//  gnt      out  4      one-hot grant (all-zero when no grant)
//  gnt_id   out  2      index of current/last winner
//  busy     out  1      1 while in GRANT
//  timeout  out  1      1-cycle pulse: grant revoked by hold timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, ptr=0, gnt_id=0, hold_cnt=0,
//   gnt=0000, busy=0, timeout=0. Reset mid-grant drops gnt immediately.
//  States: IDLE, GRANT, GAP (2-bit encoding).
//  Arbitration (in IDLE and GAP): search channels ptr, ptr+1, ptr+2, ptr+3
//   (mod 4); first with req=1 wins -> gnt_id<=winner, hold_cnt<=0,
//   next state GRANT. No req -> IDLE.
//  Latency: req sampled at edge k -> gnt[winner]=1 after edge k (1 cycle).
//  GRANT: gnt = decode(gnt_id), busy=1; hold_cnt increments each cycle.
//   Release at edge if any: done=1, req[gnt_id]=0, or
//   (HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1). On release: state<=GAP,
//   ptr<=gnt_id+1 (2-bit wrap, 3->0).
//  GAP: gnt=0000, busy=0 for exactly one cycle; arbitrates as IDLE, so
//   back-to-back grants are separated by one idle cycle.
//  timeout=1 during GAP only when release was caused solely by the counter.
//  Simultaneous done and timeout condition: treated as done, timeout=0.
//  done in IDLE/GAP: ignored. req changes of non-holders during GRANT:
//   ignored until next arbitration.
//  gnt is decoded from registered gnt_id/state: glitch-free, always one-hot
//   or zero; gnt_id holds last winner outside GRANT.
// STRUCTURE
//  Shared header arb_defs.vh: state encodings ST_IDLE=2'd0, ST_GRANT=2'd1,
//   ST_GAP=2'd2; NUM_CH=4.
//  Sub-module: grant_decoder_2to4 (in: sel[1:0], en; out: y[3:0]);
//   instantiated once, en = (state==ST_GRANT).
//  Top holds FSM, ptr, hold counter and round-robin priority logic.
// TESTING
//  1 rst_n=0, req=1111, clk toggling -> gnt=0000, busy=0, gnt_id=0, timeout=0.
//  2 req=0100 one edge -> gnt=0100, gnt_id=2, busy=1; done=1 one cycle ->
//    next cycle gnt=0000 (GAP), then IDLE with req=0000.
//  3 req=1111 held, done pulsed each grant -> winners 0,1,2,3,0, each
//    followed by exactly one gnt=0000 cycle.
//  4 after grant to ch1 (ptr=2), req=0011 -> winner ch0 (search 2,3,0).
//  5 HOLD_MAX=4, req=0001, done=0 -> gnt=0001 for 4 cycles, then gnt=0000
//    with timeout=1 for 1 cycle, then ch0 regranted (sole requester).
//  6 rst_n low mid-grant between edges -> gnt=0000 without clock edge;
//    release, req=1000 -> gnt=1000 after first edge (ptr=0).

Source files
------------

// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared state encoding, channel count and round-robin search helper.
// Purely declarative; no timing or flow control of its own.
package rr_decoder_arbiter_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Returns {found, index}: first requester at or after ptr, wrapping mod 4.
    function automatic logic [2:0] rr_pick(input logic [NUM_CH-1:0] req, input logic [1:0] ptr);
        logic [1:0] ch;
        logic [2:0] res;
        res = 3'b000;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            ch = ptr + 2'(k);
            if (req[ch]) begin
                res = {1'b1, ch};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_decoder_arbiter_grant_decoder.sv
// 2-to-4 one-hot decoder with enable; all-zero output when disabled.
// Latency: combinational. Backpressure: none.
module grant_decoder_2to4 (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b0000;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for 4 requesters with one-hot grant, hold timeout and one-cycle gap.
// Latency: request sampled at edge k is granted after edge k.
// Backpressure: non-winning requesters wait at level; holder keeps grant until done/req drop/timeout.
module rr_decoder_arbiter
    import rr_decoder_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              done,
    output logic [NUM_CH-1:0] gnt,
    output logic [1:0]        gnt_id,
    output logic              busy,
    output logic              timeout
);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       gnt_id_q, gnt_id_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;
    logic             tmo_hit;
    logic             release_now;
    logic [2:0]       pick;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_id_d    = gnt_id_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
        tmo_hit     = 1'b0;
        release_now = 1'b0;
        pick        = rr_pick(req, ptr_q);

        case (state_q)
            ST_GRANT: begin
                hold_cnt_d  = hold_cnt_q + 1'b1;
                tmo_hit     = (HOLD_MAX != 0) && (hold_cnt_q == CNT_W'(HOLD_MAX - 1));
                release_now = done || !req[gnt_id_q] || tmo_hit;
                if (release_now) begin
                    state_d = ST_GAP;
                    ptr_d   = gnt_id_q + 2'd1;
                    // Timeout flags only a counter-forced release; done takes precedence.
                    timeout_d = tmo_hit && !done && req[gnt_id_q];
                end
            end
            default: begin
                if (pick[2]) begin
                    state_d    = ST_GRANT;
                    gnt_id_d   = pick[1:0];
                    hold_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 2'd0;
            gnt_id_q   <= 2'd0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_id_q   <= gnt_id_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    grant_decoder_2to4 u_dec (
        .sel (gnt_id_q),
        .en  (state_q == ST_GRANT),
        .y   (gnt)
    );

    assign gnt_id  = gnt_id_q;
    assign busy    = (state_q == ST_GRANT);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Bench for rr_decoder_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model of the round-robin rules.
module tb_rr_decoder_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       done;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_busy;
    int m_id;
    int m_ptr;
    int m_cnt;
    bit m_tmo;

    always #5 clk = ~clk;

    rr_decoder_arbiter #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    function automatic void model_reset();
        m_busy = 0;
        m_id   = 0;
        m_ptr  = 0;
        m_cnt  = 0;
        m_tmo  = 0;
    endfunction

    function automatic void model_edge(input logic [3:0] r, input logic d);
        bit cnt_hit;
        if (m_busy) begin
            cnt_hit = (HOLD != 0) && (m_cnt == HOLD - 1);
            if (d || !r[m_id] || cnt_hit) begin
                m_tmo  = !d && r[m_id];
                m_busy = 0;
                m_ptr  = (m_id + 1) % 4;
            end else begin
                m_cnt = m_cnt + 1;
                m_tmo = 0;
            end
        end else begin
            m_tmo = 0;
            for (int k = 0; k < 4; k++) begin
                if (r[(m_ptr + k) % 4]) begin
                    m_busy = 1;
                    m_id   = (m_ptr + k) % 4;
                    m_cnt  = 0;
                    break;
                end
            end
        end
    endfunction

    function automatic logic [3:0] exp_gnt();
        return m_busy ? 4'(1 << m_id) : 4'b0000;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge(req, done);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({gnt, gnt_id, busy, timeout} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b id=%0d busy=%b to=%b, want all zero", gnt, gnt_id, busy, timeout);
        end
        req   = 4'b0000;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req = 4'b0100;
        step();
        n_checks++;
        if ({gnt, gnt_id, busy} !== {4'b0100, 2'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%b id=%0d busy=%b, want 0100/2/1", gnt, gnt_id, busy);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 4'b0000;
        n_checks++;
        if ({gnt, busy, timeout} !== 6'b0) begin
            n_fail++;
            $display("FAIL single_gap: gnt=%b busy=%b to=%b, want 0000/0/0", gnt, busy, timeout);
        end
        step();
        n_checks++;
        if ({gnt, busy, gnt_id} !== {4'b0000, 1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL single_idle: gnt=%b busy=%b id=%0d, want 0000/0/2", gnt, busy, gnt_id);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        req   = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            want = 4'(1 << (i % 4));
            n_checks++;
            if (gnt !== want || gnt_id !== 2'(i % 4)) begin
                n_fail++;
                $display("FAIL rr_winner_%0d: gnt=%b id=%0d, want %b/%0d", i, gnt, gnt_id, want, i % 4);
            end
            done = 1'b1;
            step();
            done = 1'b0;
            n_checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_gap_%0d: gnt=%b busy=%b, want 0000/0", i, gnt, busy);
            end
        end
    endtask

    task automatic test_ptr_skip();
        req = 4'b0010;
        step();
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL skip_ch1: gnt=%b, want 0010", gnt);
        end
        done = 1'b1;
        req  = 4'b0011;
        step();
        done = 1'b0;
        step();
        n_checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL skip_wrap: gnt=%b id=%0d, want 0001/0", gnt, gnt_id);
        end
    endtask

    task automatic test_timeout();
        req = 4'b0000;
        step();
        step();
        req = 4'b0001;
        for (int c = 0; c < HOLD; c++) begin
            step();
            n_checks++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle_%0d: gnt=%b to=%b, want 0001/0", c, gnt, timeout);
            end
        end
        step();
        n_checks++;
        if ({gnt, busy, timeout} !== {4'b0000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_gap: gnt=%b busy=%b to=%b, want 0000/0/1", gnt, busy, timeout);
        end
        step();
        n_checks++;
        if (gnt !== 4'b0001 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_regrant: gnt=%b to=%b, want 0001/0", gnt, timeout);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, busy, gnt_id} !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset: gnt=%b busy=%b id=%0d, want 0000/0/0", gnt, busy, gnt_id);
        end
        model_reset();
        req = 4'b1000;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            n_fail++;
            $display("FAIL post_reset_grant: gnt=%b id=%0d, want 1000/3", gnt, gnt_id);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 4) == 0);
            step();
            n_checks++;
            if ({gnt, gnt_id, busy, timeout} !== {exp_gnt(), 2'(m_id), m_busy, m_tmo}) begin
                n_fail++;
                $display("FAIL random_%0d: gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d busy=%b to=%b",
                         i, gnt, gnt_id, busy, timeout, exp_gnt(), m_id, m_busy, m_tmo);
            end
            n_checks++;
            if ($countones(gnt) > 1) begin
                n_fail++;
                $display("FAIL random_onehot_%0d: gnt=%b, want at most one bit", i, gnt);
            end
        end
        done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_ptr_skip();
        test_timeout();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
